// File: rtl/ld_sched_pkg.sv
// Shared types and constants for the layer-load scheduler: FSM states,
// SRAM target encodings and default per-job beat counts.
package ld_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LD_WS,
    ST_LD_WM,
    ST_LD_ACT,
    ST_CMP_REQ,
    ST_CMP_WAIT,
    ST_DONE
  } state_e;

  localparam logic [1:0] SEL_ACT = 2'd0;
  localparam logic [1:0] SEL_WM  = 2'd1;
  localparam logic [1:0] SEL_WS  = 2'd2;

  localparam int N_WS_DEF  = 32;
  localparam int N_WM_DEF  = 32;
  localparam int N_ACT_DEF = 3;

  localparam int CNT_W = 5;

endpackage

// File: rtl/ld_beat_cnt.sv
// Clearable beat counter with a terminal-count flag against a runtime limit.
module ld_beat_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] last,
  output logic [W-1:0] count,
  output logic         tc
);

  // clr wins over inc so the final beat of a phase leaves the count at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == last);

endmodule

// File: rtl/ld_sched.sv
// Job scheduler: streams weight-scalar, weight-matrix and activation beats into
// SRAM, then kicks the compute engine and waits for its completion pulse.
module ld_sched
  import ld_sched_pkg::*;
#(
  parameter int N_WS  = N_WS_DEF,
  parameter int N_WM  = N_WM_DEF,
  parameter int N_ACT = N_ACT_DEF
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         reuse_w_i,
  input  logic         abort_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [255:0] in_data_i,
  output logic         wen_o,
  output logic [1:0]   wsel_o,
  output logic [4:0]   waddr_o,
  output logic [255:0] wdata_o,
  output logic         cmp_start_o,
  input  logic         cmp_done_i,
  output logic         busy_o,
  output logic         job_done_o
);

  state_e             state_q, state_d;
  logic               w_loaded_q, w_loaded_d;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_last;
  logic               cnt_tc;
  logic               cnt_clr;
  logic               accept;
  logic               beat_last;
  logic [1:0]         cur_sel;

  // Input handshake: a beat transfers on any rising edge where in_valid_i and
  // in_ready_o are both high; in_ready_o is a pure decode of the state.
  assign in_ready_o = (state_q == ST_LD_WS) || (state_q == ST_LD_WM) ||
                      (state_q == ST_LD_ACT);
  assign accept     = in_valid_i && in_ready_o;
  assign beat_last  = accept && cnt_tc;

  always_comb begin
    cnt_last = '1;
    cur_sel  = SEL_ACT;
    case (state_q)
      ST_LD_WS:  begin cnt_last = CNT_W'(N_WS - 1);  cur_sel = SEL_WS; end
      ST_LD_WM:  begin cnt_last = CNT_W'(N_WM - 1);  cur_sel = SEL_WM; end
      ST_LD_ACT: begin cnt_last = CNT_W'(N_ACT - 1); cur_sel = SEL_ACT; end
      default:   ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    w_loaded_d = w_loaded_q;
    case (state_q)
      ST_IDLE:     if (start_i) state_d = (reuse_w_i && w_loaded_q) ? ST_LD_ACT : ST_LD_WS;
      ST_LD_WS:    if (beat_last) state_d = ST_LD_WM;
      ST_LD_WM:    if (beat_last) begin
                     state_d    = ST_LD_ACT;
                     w_loaded_d = 1'b1;
                   end
      ST_LD_ACT:   if (beat_last) state_d = ST_CMP_REQ;
      ST_CMP_REQ:  state_d = ST_CMP_WAIT;
      ST_CMP_WAIT: if (cmp_done_i) state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    // A partially written weight set must never be reused
    if (abort_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      if ((state_q == ST_LD_WS) || (state_q == ST_LD_WM)) w_loaded_d = 1'b0;
    end
  end

  assign cnt_clr = (state_d != state_q);

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      w_loaded_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_loaded_q <= w_loaded_d;
    end
  end

  ld_beat_cnt #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst_i),
    .clr   (cnt_clr),
    .inc   (accept),
    .last  (cnt_last),
    .count (cnt),
    .tc    (cnt_tc)
  );

  // Address/data/select hold their last written value between writes
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      wen_o   <= 1'b0;
      wsel_o  <= '0;
      waddr_o <= '0;
      wdata_o <= '0;
    end else begin
      wen_o <= accept;
      if (accept) begin
        wsel_o  <= cur_sel;
        waddr_o <= cnt;
        wdata_o <= in_data_i;
      end
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign cmp_start_o = (state_q == ST_CMP_REQ);
  assign job_done_o  = (state_q == ST_DONE);

endmodule

// File: tb/tb_ld_sched.sv
// Randomized scoreboard bench for ld_sched: the driver pushes expected SRAM
// writes derived from a job-level model; a monitor pops them as writes appear.
module tb_ld_sched;

  localparam int N_WS  = 32;
  localparam int N_WM  = 32;
  localparam int N_ACT = 3;
  localparam int W     = 263;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic         reuse_w_i = 1'b0;
  logic         abort_i = 1'b0;
  logic         in_valid_i = 1'b0;
  logic         in_ready_o;
  logic [255:0] in_data_i = '0;
  logic         wen_o;
  logic [1:0]   wsel_o;
  logic [4:0]   waddr_o;
  logic [255:0] wdata_o;
  logic         cmp_start_o;
  logic         cmp_done_i = 1'b0;
  logic         busy_o;
  logic         job_done_o;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_wr = '0;
  int           n_vec = 0;
  int           n_err = 0;
  bit           model_wl = 1'b0;

  ld_sched #(.N_WS(N_WS), .N_WM(N_WM), .N_ACT(N_ACT)) dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .reuse_w_i   (reuse_w_i),
    .abort_i     (abort_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .wen_o       (wen_o),
    .wsel_o      (wsel_o),
    .waddr_o     (waddr_o),
    .wdata_o     (wdata_o),
    .cmp_start_o (cmp_start_o),
    .cmp_done_i  (cmp_done_i),
    .busy_o      (busy_o),
    .job_done_o  (job_done_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected write for beat k of a job (k counts accepted beats from job start)
  function automatic logic [W-1:0] beat_exp(input bit full, input int k, input logic [255:0] d);
    logic [1:0] sel;
    int         a;
    if (!full)               begin sel = 2'd0; a = k; end
    else if (k < N_WS)       begin sel = 2'd2; a = k; end
    else if (k < N_WS+N_WM)  begin sel = 2'd1; a = k - N_WS; end
    else                     begin sel = 2'd0; a = k - N_WS - N_WM; end
    return {sel, 5'(a), d};
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (wen_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {wsel_o, waddr_o, wdata_o}, '1);
      end else begin
        e = exp_q.pop_front();
        chk("write", {wsel_o, waddr_o, wdata_o}, e);
        last_wr = e;
      end
    end else begin
      chk("hold", {wsel_o, waddr_o, wdata_o}, last_wr);
    end
  end

  // vmode: 0 continuous valid, 1 toggling valid, 2 random valid
  task automatic run_job(input bit reuse, input int vmode, input int abort_at,
                         input bit start_with_abort, input bit rst_in_wait);
    bit           full, v, tg;
    int           nbeats, k, wait_n;
    logic [255:0] d;
    full   = !(reuse && model_wl);
    nbeats = full ? (N_WS + N_WM + N_ACT) : N_ACT;
    tg     = 1'b1;
    @(negedge clk);
    chk("idle_busy", W'(busy_o), W'(0));
    start_i = 1'b1; reuse_w_i = reuse; abort_i = start_with_abort;
    @(negedge clk);
    start_i = 1'b0; reuse_w_i = 1'($urandom); abort_i = 1'b0;
    chk("start_busy", W'(busy_o), W'(1));
    k = 0;
    while (k < nbeats) begin
      chk("ld_ready", W'(in_ready_o), W'(1));
      chk("ld_no_cmp_start", W'(cmp_start_o), W'(0));
      case (vmode)
        0:       v = 1'b1;
        1:       begin v = tg; tg = !tg; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      if (k == abort_at) v = 1'b1;
      for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
      in_valid_i = v;
      in_data_i  = d;
      abort_i    = (k == abort_at);
      cmp_done_i = ($urandom_range(0, 7) == 0);
      start_i    = ($urandom_range(0, 7) == 0);
      if (v) exp_q.push_back(beat_exp(full, k, d));
      @(negedge clk);
      in_valid_i = 1'b0; cmp_done_i = 1'b0; start_i = 1'b0; abort_i = 1'b0;
      if (v) begin
        if (k == abort_at) begin
          if (full && k < N_WS + N_WM) model_wl = 1'b0;
          chk("abort_idle_busy", W'(busy_o), W'(0));
          chk("abort_ready", W'(in_ready_o), W'(0));
          repeat (3) begin
            chk("abort_no_done", W'(job_done_o), W'(0));
            @(negedge clk);
          end
          return;
        end
        if (full && k == N_WS + N_WM - 1) model_wl = 1'b1;
        k++;
      end
    end
    chk("cmp_start_pulse", W'(cmp_start_o), W'(1));
    chk("cmp_req_ready", W'(in_ready_o), W'(0));
    @(negedge clk);
    chk("cmp_start_single", W'(cmp_start_o), W'(0));
    chk("wait_busy", W'(busy_o), W'(1));
    wait_n = $urandom_range(0, 4);
    repeat (wait_n) begin
      start_i = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      start_i = 1'b0;
      chk("wait_no_done", W'(job_done_o), W'(0));
      chk("wait_no_start", W'(cmp_start_o), W'(0));
    end
    if (rst_in_wait) begin
      #2 rst_i = 1'b1;
      #1;
      chk("rst_outputs", {in_ready_o, wen_o, cmp_start_o, job_done_o, busy_o, wsel_o, waddr_o, wdata_o}, '0);
      last_wr  = '0;
      model_wl = 1'b0;
      @(negedge clk);
      #2 rst_i = 1'b0;
      @(negedge clk);
      cmp_done_i = 1'b1;
      @(negedge clk);
      cmp_done_i = 1'b0;
      chk("post_rst_done_ignored", W'(job_done_o), W'(0));
      chk("post_rst_idle", W'(busy_o), W'(0));
      return;
    end
    cmp_done_i = 1'b1;
    @(negedge clk);
    cmp_done_i = 1'b0;
    chk("job_done_pulse", W'(job_done_o), W'(1));
    chk("done_busy", W'(busy_o), W'(1));
    @(negedge clk);
    chk("job_done_single", W'(job_done_o), W'(0));
    chk("back_idle", W'(busy_o), W'(0));
  endtask

  initial begin
    #1;
    chk("reset_outputs", {in_ready_o, wen_o, cmp_start_o, job_done_o, busy_o, wsel_o, waddr_o, wdata_o}, '0);
    repeat (2) @(negedge clk);
    rst_i = 1'b0;

    run_job(1'b0, 0, 200, 1'b0, 1'b0);  // full job, continuous valid
    run_job(1'b1, 0, 200, 1'b0, 1'b0);  // reuse: activations only
    run_job(1'b0, 1, 200, 1'b0, 1'b0);  // toggling valid
    run_job(1'b0, 2, N_WS + 10, 1'b0, 1'b0);  // abort at WM beat 10
    run_job(1'b1, 2, 200, 1'b1, 1'b0);  // reuse after abort -> full; start beats abort
    run_job(1'b1, 0, 1, 1'b0, 1'b0);    // abort in ACT keeps weights
    run_job(1'b1, 2, 200, 1'b0, 1'b0);
    run_job(1'b1, 2, 200, 1'b0, 1'b1);  // reset during compute wait
    run_job(1'b1, 0, 200, 1'b0, 1'b0);  // reuse after reset -> full
    for (int j = 0; j < 6; j++)
      run_job(1'($urandom), 2, $urandom_range(0, 140), 1'($urandom), 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_drained", W'(exp_q.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
